// File: rtl/rv32_mem_pkg.sv
// rv32_mem_pkg: shared types for the RV32I data-memory responder.
package rv32_mem_pkg;
    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_funct3_e;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} dmem_state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  funct3;
    } mem_req_t;
endpackage

// File: rtl/dmem_sram.sv
// dmem_sram: word-organised storage with byte-lane write enables and combinational read.
module dmem_sram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk)
        if (we)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];

    assign rdata = mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding RV32I load/store responder with fixed extra latency.
module dmem_responder
    import rv32_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH30 = 30'(DEPTH_WORDS);

    dmem_state_e state;
    logic [3:0]  cnt;
    mem_req_t    cap, src;
    logic [31:0] mem_rdata, shifted, load_data, wr_data;
    logic [3:0]  be;
    logic        err, half, enter_resp;

    assign req_ready = rst && state == ST_IDLE;
    // Decode the live request in IDLE (needed when WAIT_CYCLES = 0), otherwise the captured one.
    assign src = state == ST_IDLE ? '{we: req_we, addr: req_addr, wdata: req_wdata, funct3: req_funct3} : cap;
    assign half = src.funct3[1:0] == 2'b01;
    assign err = (half && src.addr[0])
              || (src.funct3 == MEM_W && src.addr[1:0] != 2'b00)
              || src.addr[31:2] >= DEPTH30
              || (src.we ? src.funct3 > MEM_W : (src.funct3 == 3'b011 || src.funct3[2:1] == 2'b11));
    assign shifted = mem_rdata >> {src.addr[1:0], 3'b000};
    assign load_data = (src.we || err) ? 32'h0
                     : src.funct3 == MEM_B  ? {{24{shifted[7]}}, shifted[7:0]}
                     : src.funct3 == MEM_H  ? {{16{shifted[15]}}, shifted[15:0]}
                     : src.funct3 == MEM_BU ? {24'h0, shifted[7:0]}
                     : src.funct3 == MEM_HU ? {16'h0, shifted[15:0]}
                     : mem_rdata;
    assign be = src.funct3 == MEM_B ? 4'b0001 << src.addr[1:0]
              : src.funct3 == MEM_H ? (src.addr[1] ? 4'b1100 : 4'b0011)
              : 4'b1111;
    assign wr_data = src.funct3 == MEM_B ? {4{src.wdata[7:0]}}
                   : src.funct3 == MEM_H ? {2{src.wdata[15:0]}}
                   : src.wdata;
    assign enter_resp = state == ST_IDLE ? (req_valid && req_ready && WAIT_CYCLES == 0)
                                         : (state == ST_WAIT && cnt == 4'd0);

    dmem_sram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_sram (
        .clk  (clk),
        .we   (enter_resp && src.we && !err),
        .be   (be),
        .addr (src.addr[AW+1:2]),
        .wdata(wr_data),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            cap       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: if (req_valid) begin
                    cap   <= src;
                    state <= WAIT_CYCLES == 0 ? ST_RESP : ST_WAIT;
                    cnt   <= 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
                end
                ST_WAIT: if (cnt == 4'd0) state <= ST_RESP; else cnt <= cnt - 4'd1;
                // Response registers load on the first RESP cycle, one edge after the store commit.
                ST_RESP: if (!rsp_valid) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= load_data;
                    rsp_err   <= err;
                end else if (rsp_ready) begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 32'h0;
                    rsp_err   <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vectors with a scoreboard queue and an independent response monitor.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        rsp_ready = 1'b1;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    typedef struct {
        logic [31:0] rd;
        logic        er;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0, miscompares = 0, cycle = 0, vs = 0;
    logic pv = 1'b0;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired", nm);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) pv = 1'b0;
        else begin
            if (rsp_valid && !pv) vs = cycle;
            pv = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_rsp: got rdata %h err %b, required no response", rsp_rdata, rsp_err);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rd);
                    chk("rsp_err", 32'(rsp_err), 32'(e.er));
                    chk("latency", 32'(vs - e.acc), 32'd3);
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f,
                         input logic [31:0] er, input logic ee, input bit push);
        int n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) begin fail("req_ready_wait"); return; end
        req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f; req_valid = 1'b1;
        @(posedge clk); #1;
        if (push) sb.push_back('{er, ee, cycle});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !req_ready) && n < 100) begin @(negedge clk); n++; end
        if (sb.size() != 0 || !req_ready) fail("drain");
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        if (!rsp_valid) fail("rsp_valid_wait");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b0;
        #2;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", 32'(req_ready), 32'd1);

        issue(1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 0, 1);
        issue(0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 0, 1);
        issue(1, 32'h13, 32'h00000080, 3'b000, 32'h0, 0, 1);
        issue(0, 32'h13, 32'h0, 3'b000, 32'hFFFFFF80, 0, 1);
        issue(0, 32'h13, 32'h0, 3'b100, 32'h00000080, 0, 1);
        issue(0, 32'h10, 32'h0, 3'b010, 32'h80ADBEEF, 0, 1);
        issue(0, 32'h12, 32'h0, 3'b101, 32'h000080AD, 0, 1);
        issue(0, 32'h12, 32'h0, 3'b001, 32'hFFFF80AD, 0, 1);
        issue(0, 32'h11, 32'h0, 3'b000, 32'hFFFFFFBE, 0, 1);
        issue(0, 32'h10, 32'h0, 3'b100, 32'h000000EF, 0, 1);
        issue(1, 32'h16, 32'h1234ABCD, 3'b001, 32'h0, 0, 1);
        issue(0, 32'h16, 32'h0, 3'b101, 32'h0000ABCD, 0, 1);
        issue(0, 32'h16, 32'h0, 3'b001, 32'hFFFFABCD, 0, 1);
        issue(1, 32'hFFC, 32'hA5A5A5A5, 3'b010, 32'h0, 0, 1);
        issue(0, 32'hFFC, 32'h0, 3'b010, 32'hA5A5A5A5, 0, 1);

        issue(0, 32'h11, 32'h0, 3'b001, 32'h0, 1, 1);
        issue(1, 32'h12, 32'h11111111, 3'b010, 32'h0, 1, 1);
        issue(0, 32'h10, 32'h0, 3'b010, 32'h80ADBEEF, 0, 1);
        issue(0, 32'h1000, 32'h0, 3'b010, 32'h0, 1, 1);
        issue(0, 32'h10, 32'h0, 3'b011, 32'h0, 1, 1);
        issue(1, 32'h10, 32'h22222222, 3'b100, 32'h0, 1, 1);
        issue(1, 32'h11, 32'h33333333, 3'b001, 32'h0, 1, 1);
        issue(0, 32'h10, 32'h0, 3'b010, 32'h80ADBEEF, 0, 1);
        drain();

        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        issue(0, 32'h10, 32'h0, 3'b010, 32'h80ADBEEF, 0, 1);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rsp_rdata", rsp_rdata, 32'h80ADBEEF);
            chk("stall_rsp_err", 32'(rsp_err), 32'd0);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            if (i == 2) begin
                req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hFFFFFFFF; req_funct3 = 3'b010; req_valid = 1'b1;
            end else req_valid = 1'b0;
            @(negedge clk);
        end
        req_valid = 1'b0;
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        drain();
        issue(0, 32'h10, 32'h0, 3'b010, 32'h80ADBEEF, 0, 1);

        issue(1, 32'h20, 32'h0000CAFE, 3'b010, 32'h0, 0, 1);
        drain();
        issue(1, 32'h20, 32'h12345678, 3'b010, 32'h0, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("rst_wait_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_wait_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        issue(0, 32'h20, 32'h0, 3'b010, 32'h0000CAFE, 0, 1);
        drain();

        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        issue(0, 32'h20, 32'h0, 3'b100, 32'h0, 0, 0);
        wait_valid();
        chk("pre_rst_rsp_rdata", rsp_rdata, 32'h000000FE);
        #2 rst = 1'b0;
        #1;
        chk("rst_resp_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_resp_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_resp_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_resp_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        issue(0, 32'h20, 32'h0, 3'b010, 32'h0000CAFE, 0, 1);
        drain();

        repeat (5) @(negedge clk);
        chk("final_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
